// File: rtl/game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl
//
// Top-level sequencer for the keyboard battleship game. It steps through the
// start screen, ship placement for each player, alternating turns, the
// shot-result screen and game over. It also keeps each player's hit count for
// the VGA screen mux.
//
// Parameters:
//   SHIP_CELLS    ship cells per player (1..31). A player who scores this
//                 many hits wins.
//   TURN_TIMEOUT  cycles allowed per turn. It is used only when the macro
//                 TURN_TIMEOUT_EN is defined.
//
// Optional feature (macro TURN_TIMEOUT_EN):
//   defined   : a turn expires after TURN_TIMEOUT cycles without a shot.
//               Play then passes to the other player and timeout pulses.
//   undefined : no turn counter is built, timeout is 0, and a turn waits
//               indefinitely.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   enter       Enter key level; its rising edge is detected internally
//   place_done  pulse: the current player has finished placing ships
//   shot_valid  pulse: the active player has fired
//   shot_hit    hit flag, qualified by shot_valid
//   state       0 IDLE, 1 PLACE1, 2 PLACE2, 3 TURN, 4 RESULT, 5 OVER
//   start       high in every state except IDLE
//   player      active player (0 = P1, 1 = P2)
//   place_en    high in PLACE1 and PLACE2
//   fire_en     high in TURN
//   last_hit    hit flag of the most recent accepted shot
//   hits_p1/p2  hits scored by each player; saturate at SHIP_CELLS
//   game_over   high in OVER
//   winner      winning player; valid while game_over is high
//   timeout     one-cycle pulse when a turn expires
// -----------------------------------------------------------------------------
module game_flow_ctrl #(
  parameter int          SHIP_CELLS   = 17,
  parameter logic [31:0] TURN_TIMEOUT = 32'd500_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic       place_done,
  input  logic       shot_valid,
  input  logic       shot_hit,
  output logic [2:0] state,
  output logic       start,
  output logic       player,
  output logic       place_en,
  output logic       fire_en,
  output logic       last_hit,
  output logic [4:0] hits_p1,
  output logic [4:0] hits_p2,
  output logic       game_over,
  output logic       winner,
  output logic       timeout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PLACE1 = 3'd1,
    PLACE2 = 3'd2,
    TURN   = 3'd3,
    RESULT = 3'd4,
    OVER   = 3'd5
  } state_t;

  localparam logic [4:0] SHIP_MAX = 5'(SHIP_CELLS);

  state_t          state_q, state_d;
  logic            player_q, player_d;
  logic            last_hit_q, last_hit_d;
  logic            winner_q, winner_d;
  logic [1:0][4:0] hits_q, hits_d;     // indexed by player
  logic            enter_q;
  logic            enter_rise;         // registered edge pulse
  logic            turn_expire;

  // The edge pulse is registered. An Enter press therefore acts two edges
  // after the key rises, and the keyboard input never reaches the next-state
  // logic combinationally. enter_q resets high, so a key held through reset
  // release is not taken as a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enter_q    <= 1'b1;
      enter_rise <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every flop then
      // samples the values from before the edge, whatever the statement order.
      enter_q    <= enter;
      enter_rise <= enter & ~enter_q;
    end
  end

`ifdef TURN_TIMEOUT_EN
  logic [31:0] turn_cnt_q, turn_cnt_d;
  logic        timeout_q;

  // A shot on the expiry cycle wins, so expiry is qualified by ~shot_valid.
  assign turn_expire = (state_q == TURN) && !shot_valid &&
                       (turn_cnt_q == TURN_TIMEOUT - 32'd1);

  // The counter is 0 outside TURN, so it is already clear on entry. It also
  // restarts when the turn passes to the other player on expiry.
  always_comb begin
    turn_cnt_d = '0;
    if (state_q == TURN && !turn_expire) turn_cnt_d = turn_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      turn_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      turn_cnt_q <= turn_cnt_d;
      timeout_q  <= turn_expire;
    end
  end

  assign timeout = timeout_q;
`else
  assign turn_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable driven here gets a default first. Each path through
    // the case then assigns it, and no latch is inferred.
    state_d    = state_q;
    player_d   = player_q;
    last_hit_d = last_hit_q;
    winner_d   = winner_q;
    hits_d     = hits_q;

    unique case (state_q)
      IDLE: begin
        if (enter_rise) begin
          state_d  = PLACE1;
          player_d = 1'b0;
        end
      end
      PLACE1: begin
        if (place_done) begin
          state_d  = PLACE2;
          player_d = 1'b1;
        end
      end
      PLACE2: begin
        if (place_done) begin
          state_d  = TURN;
          player_d = 1'b0;
        end
      end
      TURN: begin
        if (shot_valid) begin
          last_hit_d = shot_hit;
          if (shot_hit && hits_q[player_q] < SHIP_MAX)
            hits_d[player_q] = hits_q[player_q] + 5'd1;
          state_d = RESULT;
        end else if (turn_expire) begin
          player_d = ~player_q;
        end
      end
      RESULT: begin
        if (enter_rise) begin
          if (hits_q[player_q] == SHIP_MAX) begin
            state_d  = OVER;
            winner_d = player_q;
          end else begin
            state_d  = TURN;
            player_d = ~player_q;
          end
        end
      end
      OVER: begin
        if (enter_rise) begin
          state_d    = IDLE;
          player_d   = 1'b0;
          last_hit_d = 1'b0;
          winner_d   = 1'b0;
          hits_d     = '0;
        end
      end
      default: state_d = IDLE;   // encodings 6 and 7 recover to the start screen
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      player_q   <= 1'b0;
      last_hit_q <= 1'b0;
      winner_q   <= 1'b0;
      hits_q     <= '0;
    end else begin
      state_q    <= state_d;
      player_q   <= player_d;
      last_hit_q <= last_hit_d;
      winner_q   <= winner_d;
      hits_q     <= hits_d;
    end
  end

  assign state     = state_q;
  assign start     = (state_q != IDLE);
  assign player    = player_q;
  assign place_en  = (state_q == PLACE1) || (state_q == PLACE2);
  assign fire_en   = (state_q == TURN);
  assign last_hit  = last_hit_q;
  assign hits_p1   = hits_q[0];
  assign hits_p2   = hits_q[1];
  assign game_over = (state_q == OVER);
  assign winner    = winner_q;

endmodule
